mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 82 ++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-outstanding memory port between instruction fetch and data access
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        busy
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
   state_t        state, state_nx;
   logic          own_d, own_d_nx;
   logic [CW-1:0] starve_cnt, starve_nx;
   logic          pick_d, wr, issue, rd_done;
   // state, owner and fetch-starvation counter registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         own_d      <= 1'b0;
         starve_cnt <= '0;
      end else begin
         state      <= state_nx;
         own_d      <= own_d_nx;
         starve_cnt <= starve_nx;
      end
   end
   // arbitration, next state and memory/port handshakes; outputs forced quiet while rstn is low
   always_comb begin
      pick_d    = d_req && !(if_req && starve_cnt == LIM);
      wr        = own_d && d_we;
      state_nx  = state;
      own_d_nx  = own_d;
      starve_nx = starve_cnt;
      if (state == IDLE) begin
         if (if_req || d_req) begin
            state_nx = ISSUE;
            own_d_nx = pick_d;
         end
         starve_nx = (!if_req || !pick_d) ? '0 : (starve_cnt == LIM) ? starve_cnt : starve_cnt + 1'b1;
      end else if (state == ISSUE) begin
         state_nx = mem_ready ? (wr ? IDLE : WAIT_RD) : ISSUE;
      end else begin
         state_nx = mem_rvalid ? IDLE : state;
      end
      issue     = rstn && state == ISSUE;
      rd_done   = rstn && state == WAIT_RD && mem_rvalid;
      mem_req   = issue;
      mem_we    = issue && wr;
      mem_addr  = own_d ? d_addr : if_addr;
      mem_wdata = own_d ? d_wdata : '0;
      mem_wstrb = (issue && wr) ? d_wstrb : 4'b0000;
      if_gnt    = issue && mem_ready && !own_d;
      d_gnt     = issue && mem_ready && own_d;
      if_rvalid = rd_done && !own_d;
      d_rvalid  = rd_done && own_d;
      if_rdata  = mem_rdata;
      d_rdata   = mem_rdata;
      busy      = rstn && state != IDLE;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed protocol checks followed by randomized traffic against a transaction-level model
module tb_mem_arbiter;
   localparam int LIM = 4;
   logic        clk = 0, rstn = 0;
   logic        if_req = 0, d_req = 0, d_we = 0, mem_ready = 0, mem_rvalid = 0;
   logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
   logic [3:0]  d_wstrb = 0;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   int          errors = 0, checks = 0;
   logic [31:0] mem [16];
   logic [31:0] refm [16];
   logic [31:0] exp_data, a;
   int          starve, dly, nd, nf;
   logic [3:0]  ridx;
   bit          win_d, p_if, p_d, p_win, rd_out, rv, win_now, racc;

   mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rstn(rstn),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
      for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = w[8*b +: 8];
      return o;
   endfunction

   initial begin
      tick();
      tick();
      if_req = 1;
      d_req = 1;
      smp();
      chk("rst_busy", busy, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_gnt", {if_gnt, d_gnt}, 0);
      chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
      chk("rst_wstrb", mem_wstrb, 0);
      tick();
      if_req = 0;
      d_req = 0;
      rstn = 1;
      tick();
      // single fetch
      if_req = 1; if_addr = 32'h100; mem_ready = 1;
      smp();
      chk("f_idle_req", mem_req, 0);
      tick();
      smp();
      chk("f_mem_req", mem_req, 1);
      chk("f_addr", mem_addr, 32'h100);
      chk("f_we", mem_we, 0);
      chk("f_wstrb", mem_wstrb, 0);
      chk("f_gnt", {if_gnt, d_gnt}, 2'b10);
      chk("f_busy", busy, 1);
      tick();
      if_req = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
      smp();
      chk("f_rvalid", {if_rvalid, d_rvalid}, 2'b10);
      chk("f_rdata", if_rdata, 32'hDEADBEEF);
      tick();
      mem_rvalid = 0;
      smp();
      chk("f_done_busy", busy, 0);
      tick();
      // collision: data first, then fetch
      if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000;
      smp();
      tick();
      smp();
      chk("c_gnt1", {if_gnt, d_gnt}, 2'b01);
      chk("c_addr1", mem_addr, 32'h2000);
      tick();
      d_req = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
      smp();
      chk("c_rvalid1", {if_rvalid, d_rvalid}, 2'b01);
      chk("c_rdata1", d_rdata, 32'hCAFEF00D);
      tick();
      mem_rvalid = 0;
      smp();
      chk("c_idle", mem_req, 0);
      tick();
      smp();
      chk("c_gnt2", {if_gnt, d_gnt}, 2'b10);
      chk("c_addr2", mem_addr, 32'h104);
      tick();
      if_req = 0; mem_rvalid = 1; mem_rdata = 32'h11;
      smp();
      chk("c_rvalid2", {if_rvalid, d_rvalid}, 2'b10);
      tick();
      mem_rvalid = 0;
      // write with three wait states
      d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'h12345678; d_wstrb = 4'b0011; mem_ready = 0;
      smp();
      for (int i = 0; i < 4; i++) begin
         tick();
         mem_ready = (i == 3);
         smp();
         chk("w_req", mem_req, 1);
         chk("w_we", mem_we, 1);
         chk("w_addr", mem_addr, 32'h3000);
         chk("w_wdata", mem_wdata, 32'h12345678);
         chk("w_wstrb", mem_wstrb, 4'b0011);
         chk("w_gnt", d_gnt, i == 3);
      end
      tick();
      d_req = 0; d_we = 0;
      smp();
      chk("w_done_busy", busy, 0);
      chk("w_no_rvalid", {if_rvalid, d_rvalid}, 0);
      tick();
      // stray rvalid in idle
      mem_rvalid = 1; mem_rdata = 32'hBAD;
      smp();
      chk("s_rvalid", {if_rvalid, d_rvalid}, 0);
      chk("s_busy", busy, 0);
      tick();
      mem_rvalid = 0;
      smp();
      chk("s_busy2", busy, 0);
      tick();
      // reset while waiting for read data
      if_req = 1; if_addr = 32'h200;
      smp();
      tick();
      smp();
      chk("r_gnt", if_gnt, 1);
      tick();
      if_req = 0; rstn = 0;
      smp();
      chk("r_in_rst", {busy, mem_req, if_rvalid, d_rvalid}, 0);
      tick();
      rstn = 1; mem_rvalid = 1; mem_rdata = 32'h5555;
      smp();
      chk("r_discard", {if_rvalid, d_rvalid}, 0);
      chk("r_busy", busy, 0);
      tick();
      mem_rvalid = 0; d_req = 1; d_addr = 32'h40;
      smp();
      chk("r_idle", mem_req, 0);
      tick();
      smp();
      chk("r_next_gnt", {if_gnt, d_gnt}, 2'b01);
      chk("r_next_addr", mem_addr, 32'h40);
      tick();
      d_req = 0; mem_rvalid = 1;
      smp();
      chk("r_next_rvalid", d_rvalid, 1);
      tick();
      mem_rvalid = 0;
      // starvation: both ports request continuously
      if_req = 1; if_addr = 32'h300; d_req = 1; d_addr = 32'h400; mem_ready = 1;
      nd = 0; nf = 0;
      for (int i = 0; i < 80 && nf < 2; i++) begin
         smp();
         if (d_gnt) nd++;
         if (if_gnt) begin
            chk("starve_run", nd, LIM);
            nd = 0;
            nf++;
         end
         racc = mem_req && mem_ready && !mem_we;
         tick();
         mem_rvalid = racc;
      end
      chk("starve_fetch", nf, 2);
      if_req = 0; d_req = 0;
      smp();
      tick();
      mem_rvalid = 0;
      smp();
      tick();
      // randomized traffic against the model
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         mem[i] = a;
         refm[i] = a;
      end
      starve = 0; p_if = 0; p_d = 0; p_win = 0; rd_out = 0; win_d = 0; dly = 0; ridx = 0; exp_data = 0;
      for (int c = 0; c < 4000; c++) begin
         smp();
         win_now = mem_req || rd_out;
         if (!p_win) begin
            chk("latency", mem_req, p_if || p_d);
            if (mem_req) begin
               win_d = p_d && !(p_if && starve == LIM);
               starve = (win_d && p_if) ? (starve < LIM ? starve + 1 : LIM) : 0;
            end else if (!p_if) starve = 0;
         end
         chk("busy", busy, win_now);
         chk("if_gnt", if_gnt, mem_req && mem_ready && !win_d);
         chk("d_gnt", d_gnt, mem_req && mem_ready && win_d);
         rv = rd_out && mem_rvalid;
         chk("if_rvalid", if_rvalid, rv && !win_d);
         chk("d_rvalid", d_rvalid, rv && win_d);
         if (rv) chk("rdata", win_d ? d_rdata : if_rdata, exp_data);
         if (mem_req) begin
            chk("addr", mem_addr, win_d ? d_addr : if_addr);
            chk("we", mem_we, win_d && d_we);
            chk("wstrb", mem_wstrb, (win_d && d_we) ? d_wstrb : 4'b0000);
            if (win_d && d_we) chk("wdata", mem_wdata, d_wdata);
         end
         if (mem_req && mem_ready) begin
            if (mem_we) mem[mem_addr[5:2]] = merge(mem[mem_addr[5:2]], mem_wdata, mem_wstrb);
            if (win_d && d_we) refm[d_addr[5:2]] = merge(refm[d_addr[5:2]], d_wdata, d_wstrb);
            else begin
               a = win_d ? d_addr : if_addr;
               exp_data = refm[a[5:2]];
               ridx = mem_addr[5:2];
               rd_out = 1;
               dly = $urandom_range(1, 3);
            end
         end
         if (rv) rd_out = 0;
         p_if = if_req; p_d = d_req; p_win = win_now;
         racc = if_gnt;
         nd = d_gnt;
         tick();
         if (racc || !if_req) begin
            if_req = $urandom_range(0, 1);
            if_addr = {26'h0, 4'($urandom), 2'b00};
         end
         if (nd != 0 || !d_req) begin
            d_req = $urandom_range(0, 3) != 0;
            d_we = $urandom_range(0, 1);
            d_addr = {26'h0, 4'($urandom), 2'b00};
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
         end
         mem_ready = $urandom_range(0, 2) != 0;
         if (rd_out) begin
            dly--;
            mem_rvalid = (dly == 0);
            mem_rdata = (dly == 0) ? mem[ridx] : $urandom;
         end else begin
            mem_rvalid = $urandom_range(0, 7) == 0;
            mem_rdata = $urandom;
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
